// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle controller: FSM states,
// opcode constants, ALU operation codes, ALU B-operand selects and the
// control-output bundle.
package multicycle_ctrl_pkg;

   // Controller states
   typedef enum logic [2:0] {
      FETCH   = 3'd0,
      DECODE  = 3'd1,
      EXEC_R  = 3'd2,
      EXEC_I  = 3'd3,
      BRANCH  = 3'd4,
      WB      = 3'd5,
      TRAP    = 3'd6
   } state_t;

   // Instruction class derived from the opcode
   typedef enum logic [1:0] {
      CLS_R       = 2'd0,
      CLS_I       = 2'd1,
      CLS_BRANCH  = 2'd2,
      CLS_ILLEGAL = 2'd3
   } op_class_t;

   // Supported opcodes
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;

   // ALU operation codes
   localparam logic [2:0] ALU_R     = 3'b000;
   localparam logic [2:0] ALU_BEQ   = 3'b001;
   localparam logic [2:0] ALU_ADD   = 3'b010;
   localparam logic [2:0] ALU_SLTIU = 3'b011;
   localparam logic [2:0] ALU_LUI   = 3'b100;
   localparam logic [2:0] ALU_OR    = 3'b101;
   localparam logic [2:0] ALU_BNE   = 3'b110;

   // ALU B-operand selects
   localparam logic [1:0] SRCB_RT   = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_BR   = 2'b11;

   // Everything the controller drives toward the datapath
   typedef struct packed {
      logic       mem_req;
      logic       ir_write;
      logic       pc_write;
      logic       pc_src;
      logic       reg_write;
      logic       reg_dst;
      logic       zero_ext;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_op;
      logic       illegal;
   } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle. The master side is the
// controller; the slave side is whatever supplies opcode/flags and
// consumes the controls.
interface multicycle_ctrl_if;

   logic [5:0]  instr_op_i;
   logic        zero_i;
   logic        mem_ready_i;
   logic        mem_req_o;
   logic        IRWrite_o;
   logic        PCWrite_o;
   logic        PCSrc_o;
   logic        RegWrite_o;
   logic        RegDst_o;
   logic        ZeroExt_o;
   logic        ALUSrcA_o;
   logic [1:0]  ALUSrcB_o;
   logic [2:0]  ALU_op_o;
   logic        illegal_o;
   logic [15:0] retired_o;

   modport master (
      input  instr_op_i, zero_i, mem_ready_i,
      output mem_req_o, IRWrite_o, PCWrite_o, PCSrc_o, RegWrite_o, RegDst_o,
             ZeroExt_o, ALUSrcA_o, ALUSrcB_o, ALU_op_o, illegal_o, retired_o
   );

   modport slave (
      output instr_op_i, zero_i, mem_ready_i,
      input  mem_req_o, IRWrite_o, PCWrite_o, PCSrc_o, RegWrite_o, RegDst_o,
             ZeroExt_o, ALUSrcA_o, ALUSrcB_o, ALU_op_o, illegal_o, retired_o
   );

endinterface

// File: rtl/multicycle_ctrl_op_class.sv
// Opcode classifier: maps an opcode to its instruction class and the ALU
// operation that class/opcode needs. Purely combinational.
module mc_op_class
   import multicycle_ctrl_pkg::*;
(
   input  logic [5:0] op,
   output op_class_t  op_class,
   output logic [2:0] alu_op
);

   // Decode opcode into class and ALU code; unknown opcodes are illegal
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
      op_class = CLS_ILLEGAL;
      alu_op   = ALU_R;
      unique case (op)
         OP_RTYPE: begin op_class = CLS_R;      alu_op = ALU_R;     end
         OP_ADDI:  begin op_class = CLS_I;      alu_op = ALU_ADD;   end
         OP_SLTIU: begin op_class = CLS_I;      alu_op = ALU_SLTIU; end
         OP_LUI:   begin op_class = CLS_I;      alu_op = ALU_LUI;   end
         OP_ORI:   begin op_class = CLS_I;      alu_op = ALU_OR;    end
         OP_BEQ:   begin op_class = CLS_BRANCH; alu_op = ALU_BEQ;   end
         OP_BNE:   begin op_class = CLS_BRANCH; alu_op = ALU_BNE;   end
         default:  begin op_class = CLS_ILLEGAL; alu_op = ALU_R;    end
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle instruction controller: FETCH/DECODE/EXEC/WB/BRANCH sequencing
// with an illegal-opcode trap and a 16-bit retired-instruction counter.
// The opcode is captured in DECODE; later states look only at that copy.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   multicycle_ctrl_if.master bus
);

   state_t      state;
   state_t      state_next;
   logic [5:0]  op_q;
   logic [15:0] retired_q;
   logic [5:0]  class_op;
   op_class_t   op_class;
   logic [2:0]  class_alu_op;
   logic        is_ori;
   logic        is_beq;
   logic        is_bne;
   ctrl_t       ctrl;
   ctrl_t       ctrl_out;

   // In DECODE the live opcode picks the next state; afterwards only the
   // latched copy matters, so later opcode changes are invisible.
   assign class_op = (state == DECODE) ? bus.instr_op_i : op_q;

   mc_op_class u_op_class (
      .op       (class_op),
      .op_class (op_class),
      .alu_op   (class_alu_op)
   );

   assign is_ori = (op_q == OP_ORI);
   assign is_beq = (op_q == OP_BEQ);
   assign is_bne = (op_q == OP_BNE);

   // State register
   always_ff @(posedge clk_i or negedge rst_i) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!rst_i) state <= FETCH;
      else        state <= state_next;
   end

   // Opcode capture in DECODE
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)                op_q <= '0;
      else if (state == DECODE)  op_q <= bus.instr_op_i;
   end

   // Retirement counter: one count per completed WB or BRANCH, wraps freely
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)                                retired_q <= '0;
      else if (state == WB || state == BRANCH)   retired_q <= retired_q + 16'd1;
   end

   // Next-state and per-state control outputs
   always_comb begin
      state_next = state;
      ctrl       = '0;
      unique case (state)
         FETCH: begin
            ctrl.mem_req   = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALU_ADD;
            ctrl.ir_write  = bus.mem_ready_i;
            ctrl.pc_write  = bus.mem_ready_i;
            if (bus.mem_ready_i) state_next = DECODE;
         end
         DECODE: begin
            // Precompute the branch target into ALUOut
            ctrl.alu_src_b = SRCB_BR;
            ctrl.alu_op    = ALU_ADD;
            unique case (op_class)
               CLS_R:      state_next = EXEC_R;
               CLS_I:      state_next = EXEC_I;
               CLS_BRANCH: state_next = BRANCH;
               default:    state_next = TRAP;
            endcase
         end
         EXEC_R: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_RT;
            ctrl.alu_op    = ALU_R;
            state_next     = WB;
         end
         EXEC_I: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = class_alu_op;
            ctrl.zero_ext  = is_ori;
            state_next     = WB;
         end
         WB: begin
            // Keep the execute-stage ALU setup stable while writing back
            ctrl.reg_write = 1'b1;
            ctrl.alu_src_a = 1'b1;
            if (op_class == CLS_R) begin
               ctrl.reg_dst   = 1'b1;
               ctrl.alu_src_b = SRCB_RT;
               ctrl.alu_op    = ALU_R;
            end else begin
               ctrl.alu_src_b = SRCB_IMM;
               ctrl.alu_op    = class_alu_op;
               ctrl.zero_ext  = is_ori;
            end
            state_next = FETCH;
         end
         BRANCH: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_RT;
            ctrl.alu_op    = class_alu_op;
            ctrl.pc_src    = 1'b1;
            ctrl.pc_write  = (is_beq & bus.zero_i) | (is_bne & ~bus.zero_i);
            state_next     = FETCH;
         end
         TRAP: begin
            ctrl.illegal = 1'b1;
         end
         default: begin
            state_next = FETCH;
         end
      endcase
   end

   // NOTE: outputs are gated by the async reset so an abort mid-instruction
   // kills any register/PC write immediately, not at the next clock edge.
   assign ctrl_out = rst_i ? ctrl : '0;

   assign bus.mem_req_o  = ctrl_out.mem_req;
   assign bus.IRWrite_o  = ctrl_out.ir_write;
   assign bus.PCWrite_o  = ctrl_out.pc_write;
   assign bus.PCSrc_o    = ctrl_out.pc_src;
   assign bus.RegWrite_o = ctrl_out.reg_write;
   assign bus.RegDst_o   = ctrl_out.reg_dst;
   assign bus.ZeroExt_o  = ctrl_out.zero_ext;
   assign bus.ALUSrcA_o  = ctrl_out.alu_src_a;
   assign bus.ALUSrcB_o  = ctrl_out.alu_src_b;
   assign bus.ALU_op_o   = ctrl_out.alu_op;
   assign bus.illegal_o  = ctrl_out.illegal;
   assign bus.retired_o  = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl. Inputs change on the falling edge and
// outputs are sampled 1 ns later; every expected control vector is built
// from hand-derived field values.
module tb_multicycle_ctrl;

   logic clk_i;
   logic rst_i;
   int   n_checks;
   int   n_fail;

   multicycle_ctrl_if bus ();

   multicycle_ctrl dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus.master)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Observed control vector, field order matches fv()
   logic [13:0] vec;
   assign vec = {bus.mem_req_o, bus.IRWrite_o, bus.PCWrite_o, bus.PCSrc_o,
                 bus.RegWrite_o, bus.RegDst_o, bus.ZeroExt_o, bus.ALUSrcA_o,
                 bus.ALUSrcB_o, bus.ALU_op_o, bus.illegal_o};

   function automatic logic [13:0] fv(input logic mem, input logic irw,
                                      input logic pcw, input logic pcs,
                                      input logic rw, input logic rd,
                                      input logic ze, input logic sa,
                                      input logic [1:0] sb, input logic [2:0] op,
                                      input logic ill);
      return {mem, irw, pcw, pcs, rw, rd, ze, sa, sb, op, ill};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive inputs on the falling edge, then check controls
   task automatic step(input logic [5:0] op, input logic rdy, input logic z,
                       input logic [13:0] exp, input string tag);
      @(negedge clk_i);
      bus.instr_op_i  = op;
      bus.mem_ready_i = rdy;
      bus.zero_i      = z;
      #1;
      check(tag, {18'd0, vec}, {18'd0, exp});
   endtask

   task automatic check_ret(input logic [15:0] exp, input string tag);
      check(tag, {16'd0, bus.retired_o}, {16'd0, exp});
   endtask

   logic [13:0] f_rdy, f_wait, dec, exr, wbr, trapv;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      f_rdy  = fv(1,1,1,0,0,0,0,0,2'b01,3'b010,0);
      f_wait = fv(1,0,0,0,0,0,0,0,2'b01,3'b010,0);
      dec    = fv(0,0,0,0,0,0,0,0,2'b11,3'b010,0);
      exr    = fv(0,0,0,0,0,0,0,1,2'b00,3'b000,0);
      wbr    = fv(0,0,0,0,1,1,0,1,2'b00,3'b000,0);
      trapv  = fv(0,0,0,0,0,0,0,0,2'b00,3'b000,1);

      rst_i           = 1'b0;
      bus.instr_op_i  = 6'd0;
      bus.mem_ready_i = 1'b1;
      bus.zero_i      = 1'b0;

      // Reset: all controls low even though the FSM sits in FETCH
      for (int i = 0; i < 2; i++) begin
         @(negedge clk_i); #1;
         check("rst_ctl", {18'd0, vec}, 32'd0);
         check_ret(16'd0, "rst_ret");
      end
      @(negedge clk_i);
      rst_i = 1'b1;
      bus.mem_ready_i = 1'b0;
      #1;
      check("rel_fetch", {18'd0, vec}, {18'd0, f_wait});

      // R-type; opcode garbage after DECODE must be ignored
      step(6'b000000, 1, 0, f_rdy, "r_fetch");
      step(6'b000000, 0, 0, dec,   "r_decode");
      step(6'b100011, 0, 1, exr,   "r_exec");
      step(6'b100011, 0, 0, wbr,   "r_wb");

      // ori
      step(6'b000000, 1, 0, f_rdy, "ori_fetch");
      check_ret(16'd1, "ret_after_r");
      step(6'b001101, 0, 0, dec,   "ori_decode");
      step(6'b000000, 0, 0, fv(0,0,0,0,0,0,1,1,2'b10,3'b101,0), "ori_exec");
      step(6'b000000, 0, 0, fv(0,0,0,0,1,0,1,1,2'b10,3'b101,0), "ori_wb");

      // bne, not equal -> taken
      step(6'b000000, 1, 0, f_rdy, "bne0_fetch");
      check_ret(16'd2, "ret_after_ori");
      step(6'b000101, 0, 0, dec,   "bne0_decode");
      step(6'b000000, 0, 0, fv(0,0,1,1,0,0,0,1,2'b00,3'b110,0), "bne0_branch");

      // bne, equal -> not taken
      step(6'b000000, 1, 0, f_rdy, "bne1_fetch");
      check_ret(16'd3, "ret_after_bne0");
      step(6'b000101, 0, 0, dec,   "bne1_decode");
      step(6'b000000, 0, 1, fv(0,0,0,1,0,0,0,1,2'b00,3'b110,0), "bne1_branch");

      // beq, equal -> taken
      step(6'b000000, 1, 0, f_rdy, "beq_fetch");
      check_ret(16'd4, "ret_after_bne1");
      step(6'b000100, 0, 0, dec,   "beq_decode");
      step(6'b000000, 0, 1, fv(0,0,1,1,0,0,0,1,2'b00,3'b001,0), "beq_branch");

      // Memory wait: request held, no IR/PC write until ready
      for (int i = 0; i < 5; i++) step(6'b000000, 0, 0, f_wait, "fetch_wait");
      check_ret(16'd5, "ret_after_beq");
      step(6'b000000, 1, 0, f_rdy, "addi_fetch");
      step(6'b001000, 0, 0, dec,   "addi_decode");
      step(6'b000000, 0, 0, fv(0,0,0,0,0,0,0,1,2'b10,3'b010,0), "addi_exec");
      step(6'b000000, 0, 0, fv(0,0,0,0,1,0,0,1,2'b10,3'b010,0), "addi_wb");

      // lui aborted by reset during EXEC_I: no RegWrite, counter cleared
      step(6'b000000, 1, 0, f_rdy, "lui_fetch");
      check_ret(16'd6, "ret_after_addi");
      step(6'b001111, 0, 0, dec,   "lui_decode");
      step(6'b000000, 0, 0, fv(0,0,0,0,0,0,0,1,2'b10,3'b100,0), "lui_exec");
      #2 rst_i = 1'b0;
      #1 check("abort_ctl", {18'd0, vec}, 32'd0);
      @(negedge clk_i); #1;
      check("abort_hold", {18'd0, vec}, 32'd0);
      check_ret(16'd0, "abort_ret");
      @(negedge clk_i);
      rst_i = 1'b1;
      #1 check("abort_fetch", {18'd0, vec}, {18'd0, f_wait});

      // Counter wrap via a forced preload
      force dut.retired_q = 16'hFFFF;
      step(6'b000000, 0, 0, f_wait, "wrap_idle");
      release dut.retired_q;
      check_ret(16'hFFFF, "wrap_preload");
      step(6'b000000, 1, 0, f_rdy, "sltiu_fetch");
      step(6'b001011, 0, 0, dec,   "sltiu_decode");
      step(6'b000000, 0, 0, fv(0,0,0,0,0,0,0,1,2'b10,3'b011,0), "sltiu_exec");
      step(6'b000000, 0, 0, fv(0,0,0,0,1,0,0,1,2'b10,3'b011,0), "sltiu_wb");

      // R-type then illegal opcode -> TRAP
      step(6'b000000, 1, 0, f_rdy, "r2_fetch");
      check_ret(16'h0000, "wrap_ret");
      step(6'b000000, 0, 0, dec,   "r2_decode");
      step(6'b000000, 0, 0, exr,   "r2_exec");
      step(6'b000000, 0, 0, wbr,   "r2_wb");
      step(6'b000000, 1, 0, f_rdy, "trap_fetch");
      check_ret(16'd1, "ret_before_trap");
      step(6'b100011, 1, 0, dec,   "trap_decode");
      for (int i = 0; i < 20; i++) step(6'(i), 1'(i), 1'(i >> 1), trapv, "trap_hold");
      check_ret(16'd1, "trap_ret_frozen");

      // Reset pulse leaves TRAP
      @(negedge clk_i);
      rst_i = 1'b0;
      #1 check("trap_rst_ctl", {18'd0, vec}, 32'd0);
      check_ret(16'd0, "trap_rst_ret");
      @(negedge clk_i);
      rst_i = 1'b1;
      bus.mem_ready_i = 1'b0;
      #1 check("trap_rel_fetch", {18'd0, vec}, {18'd0, f_wait});
      step(6'b000000, 1, 0, f_rdy, "post_trap_fetch");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL provide: clk_i  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL provide: rst_i  input  1  asynchronous, active-low reset.
REQ-003 SHALL provide: instr_op_i  input  6  opcode field from instruction register.
REQ-004 SHALL provide: zero_i  input  1  ALU zero flag.
REQ-005 SHALL provide: mem_ready_i  input  1  instruction memory data valid.
REQ-006 SHALL provide: mem_req_o  output  1  instruction fetch request.
REQ-007 SHALL provide: IRWrite_o, PCWrite_o, PCSrc_o, RegWrite_o, RegDst_o, ZeroExt_o, ALUSrcA_o  output  1 each  datapath controls; PCSrc_o 0=ALU result, 1=ALUOut; ALUSrcA_o 0=PC, 1=rs.
REQ-008 SHALL provide: ALUSrcB_o  output  2  00=rt, 01=const 4, 10=ext imm, 11=sign-ext imm<<2.
REQ-009 SHALL provide: ALU_op_o  output  3  R=000, beq=001, addi=010 (add), sltiu=011, lui=100, ori=101, bne=110.
REQ-010 SHALL provide: illegal_o  output  1  unsupported opcode trap.
REQ-011 SHALL provide: retired_o  output  16  retired instruction count.

Function
REQ-012 SHALL implement states FETCH, DECODE, EXEC_R, EXEC_I, BRANCH, WB, TRAP.
REQ-013 FETCH SHALL assert mem_req_o, ALUSrcA_o=0, ALUSrcB_o=01, ALU_op_o=010; IRWrite_o and PCWrite_o SHALL equal mem_ready_i; on mem_ready_i=1 go DECODE, else stay.
REQ-014 DECODE SHALL latch instr_op_i into internal opcode register, drive ALUSrcA_o=0, ALUSrcB_o=11, ALU_op_o=010 (branch target to ALUOut).
REQ-015 DECODE transitions: 000000 -> EXEC_R; 001000/001011/001111/001101 -> EXEC_I; 000100/000101 -> BRANCH; any other -> TRAP.
REQ-016 EXEC_R SHALL drive ALUSrcA_o=1, ALUSrcB_o=00, ALU_op_o=000; next WB.
REQ-017 EXEC_I SHALL drive ALUSrcA_o=1, ALUSrcB_o=10, ALU_op_o per REQ-009 from latched opcode, ZeroExt_o=1 only for ori; next WB.
REQ-018 WB SHALL assert RegWrite_o=1, RegDst_o=1 only for R-type, hold EXEC ALU controls; next FETCH; retired_o increments.
REQ-019 BRANCH SHALL drive ALUSrcA_o=1, ALUSrcB_o=00, ALU_op_o=001 (beq) or 110 (bne), PCSrc_o=1, PCWrite_o=(beq&zero_i)|(bne&~zero_i); next FETCH; retired_o increments.
REQ-020 Decisions in EXEC/WB/BRANCH SHALL use latched opcode only; instr_op_i changes after DECODE SHALL have no effect.
REQ-021 Latency excluding memory wait: R/I-type 4 cycles, branch 3 cycles.
REQ-022 TRAP SHALL hold illegal_o=1, all other controls 0, until reset; retired_o frozen.
REQ-023 retired_o SHALL wrap 0xFFFF -> 0x0000 without side effect.
REQ-024 Outputs not named for a state SHALL be 0 in that state.

Reset
REQ-025 While rst_i=0: state=FETCH, opcode register=0, retired_o=0, all outputs 0 including mem_req_o.
REQ-026 Reset asserted mid-instruction SHALL abort immediately with no register or PC write; first edge after release is in FETCH.

Structure
REQ-027 Shared package SHALL hold state enum, opcode constants, ALU_op_o codes, ALUSrcB_o encodings.
REQ-028 One sub-module mc_op_class SHALL map latched opcode to class (R/I/branch/illegal) and ALU_op_o code; FSM and counter stay in top.

Verification
REQ-029 Reset release, mem_ready_i=1, op 000000 -> states FETCH,DECODE,EXEC_R,WB; RegWrite_o=1, RegDst_o=1 in WB; retired_o=1.
REQ-030 op 001101 (ori) -> EXEC_I ALU_op_o=101, ZeroExt_o=1, ALUSrcB_o=10; WB RegDst_o=0.
REQ-031 op 000101 (bne) with zero_i=0 -> PCWrite_o=1, PCSrc_o=1; zero_i=1 -> PCWrite_o=0; both return to FETCH after 3 cycles.
REQ-032 mem_ready_i low 5 cycles in FETCH -> mem_req_o held, IRWrite_o=PCWrite_o=0 until ready.
REQ-033 op 100011 -> TRAP, illegal_o=1 stays set for 20 cycles; rst_i pulse clears to FETCH, retired_o=0.
REQ-034 Preload 0xFFFF retirements (or force), one more -> retired_o=0x0000; rst_i low during EXEC_I -> no RegWrite_o pulse.
